// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - 64-bit tagged accumulator CPU on a multiplexed address/data bus
module cpu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_data,
  input  logic [7:0]  i_tag,
  output logic [63:0] o_ad,
  output logic [7:0]  o_tag,
  output logic        o_astb,
  output logic        o_rd,
  output logic        o_wr
);

  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_ST  = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;
  localparam logic [7:0] OP_AND = 8'h05;
  localparam logic [7:0] OP_OR  = 8'h06;
  localparam logic [7:0] OP_XOR = 8'h07;
  localparam logic [7:0] OP_JMP = 8'h08;
  localparam logic [7:0] OP_JZ  = 8'h09;
  localparam logic [7:0] OP_LDI = 8'h0A;

  typedef enum logic [3:0] {
    S_FA, S_FR, S_FD, S_EX, S_MA, S_MR, S_MC, S_MW, S_HLT
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] pc_q, pc_d;
  logic [63:0] acc_q, acc_d;
  logic [7:0]  atag_q, atag_d;
  logic [63:0] ir_q, ir_d;

  logic        astb, rd, wr;
  logic [63:0] ad;
  logic [7:0]  tag;

  logic [7:0]  op;
  logic [19:0] fld_a;
  logic        unused_ir;

  assign op        = ir_q[63:56];
  assign fld_a     = ir_q[19:0];
  assign unused_ir = ^ir_q[55:20];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FA;
      pc_q    <= '0;
      acc_q   <= '0;
      atag_q  <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      atag_q  <= atag_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    atag_d  = atag_q;
    ir_d    = ir_q;
    astb    = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    ad      = '0;
    tag     = '0;
    case (state_q)
      S_FA: begin
        astb    = 1'b1;
        ad      = {44'b0, pc_q};
        state_d = S_FR;
      end
      S_FR: begin
        rd      = 1'b1;
        state_d = S_FD;
      end
      S_FD: begin
        ir_d = i_data;
        pc_d = pc_q + 20'd1;
        case (i_data[63:56])
          OP_JMP, OP_JZ, OP_LDI:                      state_d = S_EX;
          OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND,
          OP_OR, OP_XOR:                              state_d = S_MA;
          default:                                    state_d = S_HLT;
        endcase
      end
      S_EX: begin
        case (op)
          OP_JMP:  pc_d = fld_a;
          OP_JZ:   if (acc_q == 64'd0) pc_d = fld_a;
          OP_LDI:  acc_d = {44'b0, fld_a};
          default: ;
        endcase
        state_d = S_FA;
      end
      S_MA: begin
        astb    = 1'b1;
        ad      = {44'b0, fld_a};
        state_d = (op == OP_ST) ? S_MW : S_MR;
      end
      S_MR: begin
        rd      = 1'b1;
        state_d = S_MC;
      end
      // The operand tag only matters for LD; ALU results keep ATAG.
      S_MC: begin
        case (op)
          OP_LD: begin
            acc_d  = i_data;
            atag_d = i_tag;
          end
          OP_ADD:  acc_d = acc_q + i_data;
          OP_SUB:  acc_d = acc_q - i_data;
          OP_AND:  acc_d = acc_q & i_data;
          OP_OR:   acc_d = acc_q | i_data;
          OP_XOR:  acc_d = acc_q ^ i_data;
          default: ;
        endcase
        state_d = S_FA;
      end
      S_MW: begin
        wr      = 1'b1;
        ad      = acc_q;
        tag     = atag_q;
        state_d = S_FA;
      end
      S_HLT:   state_d = S_HLT;
      default: state_d = S_FA;
    endcase
  end

  // Reset holds the FSM in FA, so the bus is gated to stay quiet while it is asserted.
  assign o_astb = astb & ~reset;
  assign o_rd   = rd & ~reset;
  assign o_wr   = wr & ~reset;
  assign o_ad   = reset ? 64'd0 : ad;
  assign o_tag  = reset ? 8'd0 : tag;

endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - scoreboard bench for cpu_core with ISA-level reference model
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] i_data = '0;
  logic [7:0]  i_tag = '0;
  logic [63:0] o_ad;
  logic [7:0]  o_tag;
  logic        o_astb, o_rd, o_wr;

  cpu_core cpu (
    .clk(clk), .reset(reset), .i_data(i_data), .i_tag(i_tag),
    .o_ad(o_ad), .o_tag(o_tag), .o_astb(o_astb), .o_rd(o_rd), .o_wr(o_wr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [19:0] addr;
    logic [63:0] data;
    logic [7:0]  tag;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        exp_all[$];
  logic [63:0] mem [int];
  logic [7:0]  tg  [int];
  logic [63:0] mm  [int];
  logic [7:0]  mt  [int];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_strobe = 0;
  int exp_cycles = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic w, input logic [19:0] a, input logic [63:0] d, input logic [7:0] t);
    txn_t x;
    x.wr = w; x.addr = a; x.data = d; x.tag = t;
    return x;
  endfunction

  function automatic logic [63:0] mrd(input int a);
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction
  function automatic logic [7:0] trd(input int a);
    return tg.exists(a) ? tg[a] : 8'd0;
  endfunction
  function automatic logic [63:0] mmrd(input int a);
    return mm.exists(a) ? mm[a] : 64'd0;
  endfunction
  function automatic logic [7:0] mtrd(input int a);
    return mt.exists(a) ? mt[a] : 8'd0;
  endfunction

  function automatic logic [63:0] ins(input logic [7:0] op, input logic [19:0] a);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {op, r[55:20], a};
  endfunction

  task automatic clear_mem();
    mem.delete(); tg.delete(); mm.delete(); mt.delete();
  endtask

  task automatic put(input int a, input logic [63:0] d, input logic [7:0] t);
    mem[a] = d; tg[a] = t; mm[a] = d; mt[a] = t;
  endtask

  // Bus memory: strobes seen during a cycle take effect just after the edge that ends it.
  logic        s_astb, s_rd, s_wr;
  logic [63:0] s_ad;
  logic [7:0]  s_tag;
  logic [19:0] maddr = '0;
  always begin
    @(negedge clk);
    s_astb = o_astb; s_rd = o_rd; s_wr = o_wr; s_ad = o_ad; s_tag = o_tag;
    @(posedge clk);
    #1;
    if (s_astb) maddr = s_ad[19:0];
    if (s_rd) begin
      i_data = mrd(int'(maddr));
      i_tag  = trd(int'(maddr));
    end
    if (s_wr) begin
      mem[int'(maddr)] = s_ad;
      tg[int'(maddr)]  = s_tag;
    end
  end

  // Monitor: protocol checks every cycle, pops the scoreboard on each data cycle.
  logic [19:0] mon_addr = '0;
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0;
      last_strobe = 0;
    end else begin
      txn_t e, a;
      if (cyc == 0) chk("first_fetch", {o_astb, o_ad}, {1'b1, 64'd0});
      chk("bus_excl", 128'(($countones({o_astb, o_rd, o_wr}) <= 1)), 128'(1));
      if (o_astb) chk("astb_fmt", {o_ad[63:20], o_tag}, 128'd0);
      else if (!o_wr) chk("idle_zero", {o_ad, o_tag}, 128'd0);
      if (o_astb) mon_addr = o_ad[19:0];
      if (o_rd || o_wr) begin
        a = mk(o_wr, mon_addr, o_wr ? o_ad : 64'd0, o_wr ? o_tag : 8'd0);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_txn: got %0h expected none", a);
        end else begin
          e = exp_q.pop_front();
          chk("bus_txn", a, e);
        end
      end
      if (o_astb || o_rd || o_wr) last_strobe = cyc;
      cyc++;
    end
  end

  // Reference model: instruction-level interpreter producing the bus transactions.
  task automatic run_model();
    logic [19:0] pc;
    logic [63:0] acc, ir, v;
    logic [7:0]  atag, op;
    logic [19:0] a;
    bit done;
    pc = 0; acc = 0; atag = 0; done = 0;
    exp_all.delete();
    exp_cycles = 0;
    for (int n = 0; n < 1000 && !done; n++) begin
      ir = mmrd(int'(pc));
      exp_all.push_back(mk(1'b0, pc, 64'd0, 8'd0));
      op = ir[63:56];
      a  = ir[19:0];
      pc = pc + 20'd1;
      if (op == 8'h01) begin
        exp_all.push_back(mk(1'b0, a, 64'd0, 8'd0));
        acc = mmrd(int'(a)); atag = mtrd(int'(a));
        exp_cycles += 6;
      end else if (op == 8'h02) begin
        exp_all.push_back(mk(1'b1, a, acc, atag));
        mm[int'(a)] = acc; mt[int'(a)] = atag;
        exp_cycles += 5;
      end else if (op >= 8'h03 && op <= 8'h07) begin
        exp_all.push_back(mk(1'b0, a, 64'd0, 8'd0));
        v = mmrd(int'(a));
        case (op)
          8'h03:   acc = acc + v;
          8'h04:   acc = acc - v;
          8'h05:   acc = acc & v;
          8'h06:   acc = acc | v;
          default: acc = acc ^ v;
        endcase
        exp_cycles += 6;
      end else if (op == 8'h08) begin
        pc = a; exp_cycles += 4;
      end else if (op == 8'h09) begin
        if (acc == 0) pc = a;
        exp_cycles += 4;
      end else if (op == 8'h0A) begin
        acc = 64'(a); exp_cycles += 4;
      end else begin
        exp_cycles += 3; done = 1;
      end
    end
  endtask

  task automatic run_prog(input bit mid_rst);
    int n;
    bit halted;
    run_model();
    exp_q = exp_all;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {o_ad, o_tag, o_astb, o_rd, o_wr}, 128'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    if (mid_rst) begin
      n = 0;
      for (int k = 0; k < 100 && n < 2; k++) begin
        @(negedge clk);
        if (o_rd) n++;
      end
      #2 reset = 1'b1;
      #1 chk("reset_async", {o_ad, o_tag, o_astb, o_rd, o_wr}, 128'd0);
      exp_q = exp_all;
      @(posedge clk);
      #1 reset = 1'b0;
    end
    halted = 0;
    for (int k = 0; k < 3000 && !halted; k++) begin
      @(negedge clk);
      #1;
      if (cyc > last_strobe + 6) halted = 1;
    end
    if (!halted) begin
      total++; bad++;
      $display("FAIL halt_timeout: got running expected halted");
    end
    chk("halt_cycle", 128'(last_strobe + 2), 128'(exp_cycles));
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    foreach (mm[k]) chk("mem_final", {mrd(k), trd(k)}, {mm[k], mt[k]});
  endtask

  initial begin
    logic [7:0] op;
    int len;

    clear_mem();
    put(0, ins(8'h0A, 20'h5), 8'h00);
    put(1, ins(8'h02, 20'h100), 8'h00);
    put(2, ins(8'h00, 20'h0), 8'h00);
    run_prog(0);
    chk("ldi_st_data", mrd(32'h100), 128'd5);
    chk("ldi_st_tag", trd(32'h100), 128'd0);
    chk("ldi_st_cycles", 128'(last_strobe + 2), 128'd12);

    clear_mem();
    put(32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    put(32'h11, 64'd2, 8'h00);
    put(0, ins(8'h01, 20'h10), 8'h00);
    put(1, ins(8'h03, 20'h11), 8'h00);
    put(2, ins(8'h02, 20'h12), 8'h00);
    put(3, ins(8'h00, 20'h0), 8'h00);
    run_prog(0);
    chk("add_wrap", mrd(32'h12), 128'd1);

    clear_mem();
    put(32'h20, 64'h1234, 8'h5A);
    put(0, ins(8'h01, 20'h20), 8'h00);
    put(1, ins(8'h02, 20'h21), 8'h00);
    put(2, ins(8'h00, 20'h0), 8'h00);
    run_prog(1);
    chk("ld_tag", trd(32'h21), 128'h5A);
    chk("ld_data", mrd(32'h21), 128'h1234);

    clear_mem();
    put(0, ins(8'h09, 20'h40), 8'h00);
    put(1, ins(8'h00, 20'h0), 8'h00);
    put(32'h40, ins(8'h0A, 20'h9), 8'h00);
    put(32'h41, ins(8'h02, 20'h60), 8'h00);
    put(32'h42, ins(8'h00, 20'h0), 8'h00);
    run_prog(0);
    chk("jz_taken", mrd(32'h60), 128'd9);

    clear_mem();
    put(0, ins(8'h0A, 20'h1), 8'h00);
    put(1, ins(8'h09, 20'h40), 8'h00);
    put(2, ins(8'h02, 20'h60), 8'h00);
    put(3, ins(8'h00, 20'h0), 8'h00);
    put(32'h40, ins(8'h00, 20'h0), 8'h00);
    run_prog(0);
    chk("jz_not_taken", mrd(32'h60), 128'd1);

    clear_mem();
    put(0, ins(8'h09, 20'h30), 8'h00);
    put(1, ins(8'h02, 20'h50), 8'h00);
    put(2, ins(8'h00, 20'h0), 8'h00);
    put(32'h30, ins(8'h08, 20'hFFFFF), 8'h00);
    put(32'hFFFFF, ins(8'h0A, 20'h7), 8'h00);
    run_prog(0);
    chk("pc_wrap", mrd(32'h50), 128'd7);

    clear_mem();
    put(0, ins(8'h0A, 20'h3), 8'h00);
    put(1, ins(8'hFF, 20'h0), 8'h00);
    put(2, ins(8'h02, 20'h70), 8'h00);
    put(3, ins(8'h00, 20'h0), 8'h00);
    run_prog(0);
    chk("undef_halts", mrd(32'h70), 128'd0);

    for (int t = 0; t < 20; t++) begin
      clear_mem();
      len = $urandom_range(8, 24);
      for (int d = 0; d < 16; d++)
        put(32'h200 + d, {$urandom, $urandom}, 8'($urandom));
      for (int i = 0; i < len; i++) begin
        op = 8'($urandom_range(1, 10));
        if (op == 8'h08 || op == 8'h09)
          put(i, ins(op, 20'($urandom_range(i + 1, len))), 8'h00);
        else if (op == 8'h0A)
          put(i, ins(op, 20'($urandom)), 8'h00);
        else
          put(i, ins(op, 20'(32'h200 + $urandom_range(0, 15))), 8'h00);
      end
      case ($urandom_range(0, 2))
        0:       op = 8'h00;
        1:       op = 8'hFF;
        default: op = 8'($urandom_range(11, 254));
      endcase
      put(len, ins(op, 20'($urandom)), 8'h00);
      run_prog(t % 5 == 4 && mrd(0) >> 56 == 64'h01);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
